// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter that shares one single-port memory between
//            NREQ requesters. Only one operation is in flight at a time. The
//            memory-side signals are registered, so they change on the rising
//            edge. Read data or a write acknowledge goes back to the requester
//            that issued the operation.
// Ports    : clk, rst_n            clock, synchronous active-low reset
//            req_valid/req_write   per-requester request and direction
//            req_addr/req_wdata    per-requester fields, packed by index
//            req_ready             accept pulse to the granted requester
//            rsp_valid/rsp_rdata   completion pulse and read data
//            busy                  high while an operation is in progress
//            mem_read/mem_write    memory strobes, high for one cycle
//            mem_addr/mem_data_in  memory address and write data
//            mem_data_out          memory read data, valid one cycle after
//                                  mem_read
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     busy,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data_in,
    input  logic [DATA_W-1:0]        mem_data_out
);

    localparam int c_ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    // The pointer holds the last granted requester. Resetting it to NREQ-1
    // makes requester 0 the first candidate in the search.
    localparam logic [c_ID_W-1:0] c_PTR_RST = c_ID_W'(NREQ - 1);

    logic [1:0]        r_state;
    logic [c_ID_W-1:0] r_ptr;
    logic [c_ID_W-1:0] r_id;
    logic              r_write;

    logic              w_grant_found;
    logic [c_ID_W-1:0] w_grant_id;
    logic              w_grant_write;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [DATA_W-1:0] w_grant_wdata;
    logic [NREQ-1:0]   w_id_onehot;

    // Requester index that is `step` positions after `base`, modulo NREQ.
    function automatic logic [c_ID_W-1:0] f_rot(input logic [c_ID_W-1:0] base,
                                                input int step);
        return c_ID_W'((int'(base) + step) % NREQ);
    endfunction

    // Scan from lowest to highest priority, so the last hit wins. Offset 1
    // from the pointer has the highest priority, and the pointer itself has
    // the lowest.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[f_rot(r_ptr, k)]) begin
                w_grant_found = 1'b1;
                w_grant_id    = f_rot(r_ptr, k);
            end
        end
    end

    assign w_grant_write = req_write[w_grant_id];
    assign w_grant_addr  = req_addr[int'(w_grant_id)*ADDR_W +: ADDR_W];
    assign w_grant_wdata = req_wdata[int'(w_grant_id)*DATA_W +: DATA_W];
    assign w_id_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << r_id;

    // Ready is combinational. A requester that drops valid before its grant
    // is therefore never accepted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == c_IDLE) && w_grant_found) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    assign busy = (r_state != c_IDLE);

    // mem_addr and mem_data_in act as the operation latch. They keep their
    // values until the next grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_ptr       <= c_PTR_RST;
            r_id        <= '0;
            r_write     <= 1'b0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            rsp_valid <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_found) begin
                        r_id        <= w_grant_id;
                        r_ptr       <= w_grant_id;
                        r_write     <= w_grant_write;
                        mem_addr    <= w_grant_addr;
                        mem_data_in <= w_grant_wdata;
                        mem_write   <= w_grant_write;
                        mem_read    <= ~w_grant_write;
                        r_state     <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (r_write) begin
                        rsp_valid <= w_id_onehot;
                        rsp_rdata <= '0;
                        r_state   <= c_RESP;
                    end else begin
                        r_state   <= c_CAPTURE;
                    end
                end
                c_CAPTURE: begin
                    rsp_rdata <= mem_data_out;
                    rsp_valid <= w_id_onehot;
                    r_state   <= c_RESP;
                end
                c_RESP: begin
                    rsp_rdata <= '0;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard testbench for mem_arbiter with a 32x8 memory model.
//            The stimulus pushes hand-computed grants, strobes and responses.
//            A monitor pops and compares them as the DUT presents each one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   busy;
    logic                   mem_read;
    logic                   mem_write;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_data_in;
    logic [DATA_W-1:0]      mem_data_out;

    always #5 clk = ~clk;

    mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .busy         (busy),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Memory model: synchronous write, registered read data.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read)  mem_data_out  <= mem[mem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t_acc = 0;
    bit last_w = 1'b0;

    int         q_grant[$];
    logic [13:0] q_mem[$];   // {write, addr[4:0], data[7:0]}
    logic [11:0] q_rsp[$];   // {id[3:0], rdata[7:0]}

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected grant, strobe and (optionally) response for one operation.
    task automatic expect_op(input int id, input bit w, input logic [4:0] a,
                             input logic [7:0] d, input logic [7:0] rd, input bit has_rsp);
        q_grant.push_back(id);
        q_mem.push_back({w, a, d});
        if (has_rsp) q_rsp.push_back({4'(id), rd});
    endtask

    // One requester: raise the request and hold it until ready. Then drop
    // valid and scramble the fields, which must not affect the operation.
    task automatic req_op(input int id, input bit w, input logic [4:0] a, input logic [7:0] d);
        bit got = 1'b0;
        @(posedge clk); #1;
        req_valid[id]              = 1'b1;
        req_write[id]              = w;
        req_addr[id*ADDR_W +: 5]   = a;
        req_wdata[id*DATA_W +: 8]  = d;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("ready_seen_req%0d", id), 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[id]              = 1'b0;
        req_write[id]              = ~w;
        req_addr[id*ADDR_W +: 5]   = ~a;
        req_wdata[id*DATA_W +: 8]  = ~d;
    endtask

    task automatic drain();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (q_grant.size() == 0 && q_mem.size() == 0 && q_rsp.size() == 0 && !busy) break;
        end
        check("drain_queues", 32'(q_grant.size() + q_mem.size() + q_rsp.size()), 32'd0);
    endtask

    // Monitor: compare every grant, strobe and response against the queues.
    initial begin
        int         g;
        logic [13:0] em;
        logic [11:0] er;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_ready != '0) begin
                    if (q_grant.size() == 0) check("unexpected_grant", 32'(req_ready), 32'd0);
                    else begin
                        g = q_grant.pop_front();
                        check("grant_id", 32'(req_ready), 32'(1 << g));
                        check("grant_not_busy", 32'(busy), 32'd0);
                        t_acc = cyc;
                    end
                end
                if (mem_read || mem_write) begin
                    check("one_strobe", 32'(mem_read & mem_write), 32'd0);
                    check("strobe_latency", 32'(cyc), 32'(t_acc + 1));
                    last_w = mem_write;
                    if (q_mem.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
                    else begin
                        em = q_mem.pop_front();
                        check("strobe_kind", 32'(mem_write), 32'(em[13]));
                        check("strobe_addr", 32'(mem_addr), 32'(em[12:8]));
                        if (em[13]) check("strobe_wdata", 32'(mem_data_in), 32'(em[7:0]));
                    end
                end
                if (rsp_valid != '0) begin
                    if (q_rsp.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                    else begin
                        er = q_rsp.pop_front();
                        check("rsp_id", 32'(rsp_valid), 32'(1 << er[11:8]));
                        check("rsp_rdata", 32'(rsp_rdata), 32'(er[7:0]));
                        check("rsp_latency", 32'(cyc), 32'(t_acc + (last_w ? 2 : 3)));
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"},  32'(req_ready),   32'd0);
        check({tag, "_rsp"},    32'(rsp_valid),   32'd0);
        check({tag, "_rdata"},  32'(rsp_rdata),   32'd0);
        check({tag, "_busy"},   32'(busy),        32'd0);
        check({tag, "_strobe"}, 32'({mem_read, mem_write}), 32'd0);
        check({tag, "_addr"},   32'(mem_addr),    32'd0);
        check({tag, "_wdata"},  32'(mem_data_in), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h77;
        mem_data_out = '0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset");

        // Single write, then read-back by the other requester.
        expect_op(0, 1'b1, 5'd5, 8'hA5, 8'h00, 1'b1);
        req_op(0, 1'b1, 5'd5, 8'hA5);
        drain();
        expect_op(1, 1'b0, 5'd5, 8'h00, 8'hA5, 1'b1);
        req_op(1, 1'b0, 5'd5, 8'h00);
        drain();

        // Collision with the pointer at 1: requester 0 wins.
        expect_op(0, 1'b1, 5'd10, 8'h3C, 8'h00, 1'b1);
        expect_op(1, 1'b1, 5'd11, 8'hC3, 8'h00, 1'b1);
        fork
            req_op(0, 1'b1, 5'd10, 8'h3C);
            req_op(1, 1'b1, 5'd11, 8'hC3);
        join
        drain();
        // Single op from requester 0 moves the pointer to 0, so the next
        // collision goes to requester 1 first.
        expect_op(0, 1'b0, 5'd10, 8'h00, 8'h3C, 1'b1);
        req_op(0, 1'b0, 5'd10, 8'h00);
        drain();
        expect_op(1, 1'b0, 5'd10, 8'h00, 8'h3C, 1'b1);
        expect_op(0, 1'b0, 5'd11, 8'h00, 8'hC3, 1'b1);
        fork
            req_op(0, 1'b0, 5'd11, 8'h00);
            req_op(1, 1'b0, 5'd10, 8'h00);
        join
        drain();

        // Saturation: the pointer is at 0, so grants run 1,0,1,0,...
        for (int k = 0; k < 4; k++) begin
            expect_op(1, 1'b0, 5'd10, 8'h00, 8'h3C, 1'b1);
            expect_op(0, 1'b1, 5'(20 + k), 8'(8'h50 + k), 8'h00, 1'b1);
        end
        fork
            for (int k = 0; k < 4; k++) req_op(0, 1'b1, 5'(20 + k), 8'(8'h50 + k));
            for (int j = 0; j < 4; j++) req_op(1, 1'b0, 5'd10, 8'h00);
        join
        drain();

        // Boundary addresses.
        expect_op(0, 1'b1, 5'd0,  8'h00, 8'h00, 1'b1);
        req_op(0, 1'b1, 5'd0, 8'h00);
        expect_op(0, 1'b1, 5'd31, 8'hFF, 8'h00, 1'b1);
        req_op(0, 1'b1, 5'd31, 8'hFF);
        expect_op(1, 1'b0, 5'd0,  8'h00, 8'h00, 1'b1);
        req_op(1, 1'b0, 5'd0, 8'h00);
        expect_op(1, 1'b0, 5'd31, 8'h00, 8'hFF, 1'b1);
        req_op(1, 1'b0, 5'd31, 8'h00);
        drain();

        // Reset during CAPTURE: strobe expected, response not expected.
        expect_op(1, 1'b0, 5'd31, 8'h00, 8'h00, 1'b0);
        req_op(1, 1'b0, 5'd31, 8'h00);   // returns in the ISSUE cycle
        @(posedge clk); #1;               // CAPTURE cycle
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("midreset");
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        // The pointer is back at 1, so requester 0 is granted first.
        expect_op(0, 1'b1, 5'd7, 8'h11, 8'h00, 1'b1);
        expect_op(1, 1'b0, 5'd7, 8'h00, 8'h11, 1'b1);
        fork
            req_op(0, 1'b1, 5'd7, 8'h11);
            req_op(1, 1'b0, 5'd7, 8'h00);
        join
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
